// File: rtl/scan_decoder.sv
// Registered N-to-2^N line decoder with enable, output polarity select and a
// timed auto-scan mode that dwells PRESCALE cycles on each enabled line.
module scan_decoder #(
    parameter  int unsigned SEL_W      = 2,
    parameter  int unsigned PRESCALE   = 100000,
    parameter  bit          ACTIVE_LOW = 1'b0,
    localparam int unsigned NOUT       = 1 << SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    input  logic [NOUT-1:0]  mask,
    output logic [NOUT-1:0]  dec_out,
    output logic [SEL_W-1:0] idx,
    output logic             step
);

    localparam int unsigned   PW       = $clog2(PRESCALE);
    localparam logic [PW-1:0] TERM     = PW'(PRESCALE - 1);
    localparam logic [NOUT-1:0] INACTIVE = {NOUT{ACTIVE_LOW}};

    logic [PW-1:0]    presc;
    logic [PW-1:0]    presc_next;
    logic             mode_q;
    logic             mode_rise;
    logic [SEL_W-1:0] scan_next;
    logic [SEL_W-1:0] idx_next;
    logic             step_next;
    logic [NOUT-1:0]  act;
    logic [NOUT-1:0]  dec_next;

    assign mode_rise = mode & ~mode_q;

    // Circular search for the nearest enabled line after idx; walking the
    // distance downwards lets the closest hit win. Distance NOUT is idx itself.
    always_comb begin : next_scan_index
        scan_next = idx;
        for (int unsigned k = NOUT; k >= 1; k--) begin
            if (mask[SEL_W'(32'(idx) + k)]) begin
                scan_next = SEL_W'(32'(idx) + k);
            end
        end
    end

    // Next index, prescaler and step; en=0 dominates, then mode entry, then terminal count.
    always_comb begin : next_state
        presc_next = presc;
        idx_next   = idx;
        step_next  = 1'b0;
        act        = '0;
        if (!en) begin
            presc_next = '0;
        end else if (!mode || mode_rise) begin
            presc_next = '0;
            idx_next   = sel;
        end else if (presc == TERM) begin
            presc_next = '0;
            idx_next   = scan_next;
            step_next  = 1'b1;
        end else begin
            presc_next = presc + PW'(1);
        end
        for (int unsigned i = 0; i < NOUT; i++) begin
            act[i] = en & mask[i] & (idx_next == SEL_W'(i));
        end
        dec_next = ACTIVE_LOW ? ~act : act;
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            presc   <= '0;
            idx     <= '0;
            step    <= 1'b0;
            mode_q  <= 1'b0;
            dec_out <= INACTIVE;
        end else begin
            presc   <= presc_next;
            idx     <= idx_next;
            step    <= step_next;
            mode_q  <= mode;
            dec_out <= dec_next;
        end
    end

endmodule
